menu_ctrl: RTL and testbench
============================

Name: menu_ctrl

Overview:
- Sequencer for the on-screen menu/text overlay.
- Turns held key codes from the keyboard decoder into single press events and runs the MENU/TEXT1/TEXT2/TEXT3 screen FSM.
- Keeps a per-text page index and an idle timeout.
- Commits every screen/page change only at a frame boundary (vsync rising edge), so the text renderer and font-ROM address logic never switch mid-frame. Sits between the keyboard decoder and the menu text renderer.

Parameters:
- N_PAGES, 4, pages per text screen; page index saturates at N_PAGES-1.
- TIMEOUT_FRAMES, 1800, idle frames in a TEXT screen before automatic return to MENU (30 s at 60 Hz).
- FCNT_W, 11, width of the idle frame counter; must satisfy 2**FCNT_W > TIMEOUT_FRAMES.

Ports:
- clk  in  1  pixel clock, single clock domain.
- rst  in  1  asynchronous, active-low reset.
- key  in  4  held key code from the keyboard decoder; key_none when no key is down.
- vsync  in  1  vsync from the VGA timing chain; its rising edge is the frame tick.
- state_out  out  2  committed screen: MENU=2'b00, TEXT1=2'b01, TEXT2=2'b11, TEXT3=2'b10.
- select_text  out  2  text ROM select: MENU 0, TEXT1 1, TEXT2 2, TEXT3 3.
- page  out  2  committed page index within the current text; 0 in MENU.
- update  out  1  one-cycle pulse in the cycle the committed state or page changes.
- pending  out  1  high while a press is latched and waiting for a frame tick.

Behaviour:
- Reset (rst=0, async): state MENU, page 0, update 0, pending 0, idle counter 0, key_prev key_none, vsync_prev 0. All outputs read 0.
- Press event: key != key_prev and key != key_none. key_prev is registered every cycle.
  - Holding a key gives exactly one event.
  - Changing directly from one code to another gives a new event.
- Frame tick: vsync=1 and vsync_prev=0, from a registered vsync_prev.
- Command latch: one-entry register cmd plus flag pending, set on a press event.
  - A second press before the tick overwrites cmd; last press wins.
- Commit happens on the tick only; state/page change 1 cycle after the tick cycle, and update pulses together with that change.
  - A press in the same cycle as the tick is latched for the next tick, not applied now.
  - pending clears on commit whether or not the command is legal in the current state.
- Transitions:
  - MENU: key_2 goes to TEXT1, key_3 to TEXT2, key_4 to TEXT3; any other command is ignored.
  - Entering any TEXT state forces page 0.
  - TEXTx: key_esc goes to MENU and forces page 0.
  - TEXTx: key_down increments page, saturating at N_PAGES-1.
  - TEXTx: key_up decrements page, saturating at 0.
  - TEXTx: key_2/3/4 jump directly to another text screen (page 0); the same screen is a no-op.
  - A no-op commit (saturated page, same screen, illegal key) gives no update pulse.
- Idle timeout: the counter is meaningful only in TEXT states.
  - Cleared on any press event and on any state change; increments on each tick otherwise.
  - On the tick where the counter equals TIMEOUT_FRAMES-1 and nothing is pending: go to MENU, page 0, update pulse.
  - If a command is pending on that tick, the command wins and the counter clears.
  - The counter holds 0 in MENU.
- select_text is a registered decode of the committed state and follows state_out in the same cycle.
- Asserting rst mid-frame or with a command pending discards the command; there are no partial commits.

Decomposition:
- vga_pkg holds the screen enum type (menu_state_t, encoding above) and the key constants key_none=4'h0, key_2=4'h2, key_3=4'h3, key_4=4'h4, key_up=4'h8, key_down=4'h9, key_esc=4'hE.
- Renderer and controller share these definitions.
- One sub-module: key_edge (key_prev register plus press-event detect, outputs event and code); it is reusable by other key consumers.
- The FSM, page and timeout logic stay in menu_ctrl.

Test Plan:
- Reset, then key=key_3 held 5000 cycles with one vsync edge: exactly one update pulse, state_out=2'b11, select_text=2, page=0, pending low after the commit.
- In TEXT1, key_down pressed 5 times across 5 frames (N_PAGES=4): page goes 1,2,3,3,3; update pulses only 3 times.
- In MENU, press key_2 then key_4 within one frame: after the tick state_out=2'b10, a single update pulse.
- Press coincident with the vsync rising edge: no change at that tick; commit on the following tick.
- In TEXT2, no keys for TIMEOUT_FRAMES=3 (override) ticks: state_out returns to 2'b00 on the 3rd tick, page 0. Repeat with key_down pressed before the 3rd tick: stays in TEXT2, page=1, counter restarts.
- Assert rst mid-frame with a key_esc pending in TEXT3: outputs 0 immediately (async); after release, no commit occurs on the next tick.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared definitions for the menu controller and the text renderer: screen
// encoding, keyboard codes and small decode helpers.
package vga_pkg;

   typedef enum logic [1:0] {
      StMenu  = 2'b00,
      StText1 = 2'b01,
      StText2 = 2'b11,
      StText3 = 2'b10
   } menu_state_t;

   localparam logic [3:0] key_none = 4'h0;
   localparam logic [3:0] key_2    = 4'h2;
   localparam logic [3:0] key_3    = 4'h3;
   localparam logic [3:0] key_4    = 4'h4;
   localparam logic [3:0] key_up   = 4'h8;
   localparam logic [3:0] key_down = 4'h9;
   localparam logic [3:0] key_esc  = 4'hE;

   // Text ROM select for a screen; the state encoding is Gray, the ROM index is not.
   function automatic logic [1:0] text_sel(input menu_state_t s);
      logic [1:0] sel;
      unique case (s)
         StMenu:  sel = 2'd0;
         StText1: sel = 2'd1;
         StText2: sel = 2'd2;
         StText3: sel = 2'd3;
         default: sel = 2'd0;
      endcase
      return sel;
   endfunction

   // Screen reached by a screen-select key; only valid for key_2/key_3/key_4.
   function automatic menu_state_t key_screen(input logic [3:0] k);
      menu_state_t s;
      if (k == key_2) begin
         s = StText1;
      end else if (k == key_3) begin
         s = StText2;
      end else begin
         s = StText3;
      end
      return s;
   endfunction

endpackage

// File: rtl/key_edge.sv
// Turns a held key code into a single-cycle press event; a change from one
// code directly to another counts as a new press.
module key_edge
   import vga_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] key_i,
   output logic       event_o,
   output logic [3:0] code_o
);

   logic [3:0] key_prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         key_prev_q <= key_none;
      end else begin
         key_prev_q <= key_i;
      end
   end

   assign event_o = (key_i != key_prev_q) && (key_i != key_none);
   assign code_o  = key_i;

endmodule

// File: rtl/menu_ctrl.sv
// Menu/text overlay sequencer: latches key presses and commits screen/page
// changes only on the vsync rising edge, plus an idle timeout back to MENU.
module menu_ctrl
   import vga_pkg::*;
#(
   parameter int unsigned N_PAGES        = 4,
   parameter int unsigned TIMEOUT_FRAMES = 1800,
   parameter int unsigned FCNT_W         = 11
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] key_i,
   input  logic       vsync_i,
   output logic [1:0] state_out_o,
   output logic [1:0] select_text_o,
   output logic [1:0] page_o,
   output logic       update_o,
   output logic       pending_o
);

   localparam logic [1:0]        PageMax  = 2'(N_PAGES - 1);
   localparam logic [FCNT_W-1:0] IdleLast = FCNT_W'(TIMEOUT_FRAMES - 1);

   logic              press;
   logic [3:0]        press_code;
   logic              tick;
   logic              vsync_prev_q;
   menu_state_t       state_q, state_d;
   logic [1:0]        page_q, page_d;
   logic [1:0]        sel_q;
   logic              update_q, update_d;
   logic [3:0]        cmd_q, cmd_d;
   logic              pending_q, pending_d;
   logic [FCNT_W-1:0] idle_q, idle_d;

   key_edge u_key_edge (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .key_i   (key_i),
      .event_o (press),
      .code_o  (press_code)
   );

   assign tick = vsync_i && !vsync_prev_q;

   always_comb begin
      state_d = state_q;
      page_d  = page_q;
      if (tick) begin
         if (pending_q) begin
            unique case (cmd_q)
               key_2, key_3, key_4: begin
                  if (key_screen(cmd_q) != state_q) begin
                     state_d = key_screen(cmd_q);
                     page_d  = 2'd0;
                  end
               end
               key_esc: begin
                  state_d = StMenu;
                  page_d  = 2'd0;
               end
               key_down: begin
                  if (state_q != StMenu && page_q != PageMax) page_d = page_q + 2'd1;
               end
               key_up: begin
                  if (state_q != StMenu && page_q != 2'd0) page_d = page_q - 2'd1;
               end
               default: ;
            endcase
         end else if (state_q != StMenu && idle_q == IdleLast) begin
            state_d = StMenu;
            page_d  = 2'd0;
         end
      end
      update_d = (state_d != state_q) || (page_d != page_q);
   end

   // A press in the tick cycle survives the commit and waits for the next tick.
   always_comb begin
      cmd_d     = press ? press_code : cmd_q;
      pending_d = pending_q;
      if (tick) pending_d = 1'b0;
      if (press) pending_d = 1'b1;
   end

   always_comb begin
      idle_d = idle_q;
      if (press || state_d != state_q || state_d == StMenu) begin
         idle_d = '0;
      end else if (tick) begin
         idle_d = pending_q ? '0 : idle_q + FCNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vsync_prev_q <= 1'b0;
         state_q      <= StMenu;
         page_q       <= 2'd0;
         sel_q        <= 2'd0;
         update_q     <= 1'b0;
         cmd_q        <= key_none;
         pending_q    <= 1'b0;
         idle_q       <= '0;
      end else begin
         vsync_prev_q <= vsync_i;
         state_q      <= state_d;
         page_q       <= page_d;
         sel_q        <= text_sel(state_d);
         update_q     <= update_d;
         cmd_q        <= cmd_d;
         pending_q    <= pending_d;
         idle_q       <= idle_d;
      end
   end

   assign state_out_o   = state_q;
   assign select_text_o = sel_q;
   assign page_o        = page_q;
   assign update_o      = update_q;
   assign pending_o     = pending_q;

endmodule

// File: tb/tb_menu_ctrl.sv
// Directed bench for menu_ctrl with a shortened idle timeout of 3 frames.
module tb_menu_ctrl;
   import vga_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] key = 4'h0;
   logic       vsync = 1'b0;
   logic [1:0] state_out, select_text, page;
   logic       update, pending;

   int errors = 0;
   int checks = 0;
   int upd_cnt = 0;

   menu_ctrl #(
      .N_PAGES        (4),
      .TIMEOUT_FRAMES (3),
      .FCNT_W         (11)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .key_i         (key),
      .vsync_i       (vsync),
      .state_out_o   (state_out),
      .select_text_o (select_text),
      .page_o        (page),
      .update_o      (update),
      .pending_o     (pending)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (update === 1'b1) upd_cnt++;

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] k);
      key = k;
      cyc(1);
      key = 4'h0;
      cyc(1);
   endtask

   task automatic frame();
      vsync = 1'b1;
      cyc(2);
      vsync = 1'b0;
      cyc(2);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      key   = 4'h0;
      vsync = 1'b0;
      cyc(3);
      checks++; if (state_out !== 2'b00) begin errors++; $display("FAIL reset_state got=%b exp=00", state_out); end
      checks++; if (select_text !== 2'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", select_text); end
      checks++; if (page !== 2'd0) begin errors++; $display("FAIL reset_page got=%0d exp=0", page); end
      checks++; if (update !== 1'b0 || pending !== 1'b0) begin errors++; $display("FAIL reset_flags got upd=%b pend=%b exp 0/0", update, pending); end
      rst_n = 1'b1;
      cyc(2);
   endtask

   task automatic test_hold_key();
      upd_cnt = 0;
      key = 4'h3;
      cyc(1000);
      checks++; if (pending !== 1'b1 || state_out !== 2'b00) begin errors++; $display("FAIL hold_wait got pend=%b state=%b exp 1/00", pending, state_out); end
      vsync = 1'b1;
      cyc(3);
      vsync = 1'b0;
      cyc(3997);
      key = 4'h0;
      cyc(2);
      checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL hold_updates got=%0d exp=1", upd_cnt); end
      checks++; if (state_out !== 2'b11) begin errors++; $display("FAIL hold_state got=%b exp=11", state_out); end
      checks++; if (select_text !== 2'd2) begin errors++; $display("FAIL hold_sel got=%0d exp=2", select_text); end
      checks++; if (page !== 2'd0 || pending !== 1'b0) begin errors++; $display("FAIL hold_page_pend got page=%0d pend=%b exp 0/0", page, pending); end
   endtask

   task automatic test_pages();
      logic [1:0] exp_page [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      press(4'h2);
      frame();
      checks++; if (state_out !== 2'b01 || select_text !== 2'd1) begin errors++; $display("FAIL jump_text1 got state=%b sel=%0d exp 01/1", state_out, select_text); end
      upd_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         press(4'h9);
         frame();
         checks++; if (page !== exp_page[i]) begin errors++; $display("FAIL page_down%0d got=%0d exp=%0d", i, page, exp_page[i]); end
      end
      checks++; if (upd_cnt !== 3) begin errors++; $display("FAIL page_updates got=%0d exp=3", upd_cnt); end
      press(4'h8);
      frame();
      checks++; if (page !== 2'd2) begin errors++; $display("FAIL page_up got=%0d exp=2", page); end
      press(4'h3);
      press(4'h3);
      frame();
      press(4'h3);
      frame();
      checks++; if (state_out !== 2'b11 || page !== 2'd0) begin errors++; $display("FAIL text_jump got state=%b page=%0d exp 11/0", state_out, page); end
      press(4'h9);
      frame();
      upd_cnt = 0;
      press(4'h3);
      frame();
      checks++; if (page !== 2'd1 || upd_cnt !== 0) begin errors++; $display("FAIL same_screen got page=%0d upd=%0d exp 1/0", page, upd_cnt); end
      press(4'hE);
      frame();
      checks++; if (state_out !== 2'b00 || page !== 2'd0) begin errors++; $display("FAIL esc got state=%b page=%0d exp 00/0", state_out, page); end
   endtask

   task automatic test_last_wins();
      upd_cnt = 0;
      press(4'h9);
      frame();
      checks++; if (state_out !== 2'b00 || page !== 2'd0 || upd_cnt !== 0) begin errors++; $display("FAIL menu_ignore got state=%b page=%0d upd=%0d exp 00/0/0", state_out, page, upd_cnt); end
      key = 4'h2;
      cyc(3);
      key = 4'h4;
      cyc(3);
      key = 4'h0;
      cyc(2);
      frame();
      checks++; if (state_out !== 2'b10 || select_text !== 2'd3) begin errors++; $display("FAIL last_wins got state=%b sel=%0d exp 10/3", state_out, select_text); end
      checks++; if (upd_cnt !== 1) begin errors++; $display("FAIL last_wins_upd got=%0d exp=1", upd_cnt); end
   endtask

   task automatic test_coincident();
      upd_cnt = 0;
      key   = 4'hE;
      vsync = 1'b1;
      cyc(1);
      key = 4'h0;
      cyc(1);
      vsync = 1'b0;
      cyc(2);
      checks++; if (state_out !== 2'b10 || pending !== 1'b1 || upd_cnt !== 0) begin errors++; $display("FAIL coinc_hold got state=%b pend=%b upd=%0d exp 10/1/0", state_out, pending, upd_cnt); end
      frame();
      checks++; if (state_out !== 2'b00 || pending !== 1'b0 || upd_cnt !== 1) begin errors++; $display("FAIL coinc_commit got state=%b pend=%b upd=%0d exp 00/0/1", state_out, pending, upd_cnt); end
   endtask

   task automatic test_timeout();
      press(4'h3);
      frame();
      upd_cnt = 0;
      frame();
      frame();
      checks++; if (state_out !== 2'b11) begin errors++; $display("FAIL timeout_early got=%b exp=11", state_out); end
      frame();
      checks++; if (state_out !== 2'b00 || page !== 2'd0 || upd_cnt !== 1) begin errors++; $display("FAIL timeout got state=%b page=%0d upd=%0d exp 00/0/1", state_out, page, upd_cnt); end
      press(4'h3);
      frame();
      frame();
      frame();
      press(4'h9);
      frame();
      checks++; if (state_out !== 2'b11 || page !== 2'd1) begin errors++; $display("FAIL timeout_cmd got state=%b page=%0d exp 11/1", state_out, page); end
      frame();
      frame();
      checks++; if (state_out !== 2'b11) begin errors++; $display("FAIL timeout_restart got=%b exp=11", state_out); end
      frame();
      checks++; if (state_out !== 2'b00 || page !== 2'd0) begin errors++; $display("FAIL timeout_again got state=%b page=%0d exp 00/0", state_out, page); end
   endtask

   task automatic test_reset_pending(input logic [3:0] k);
      press(4'h4);
      frame();
      press(4'h9);
      frame();
      press(k);
      checks++; if (pending !== 1'b1 || state_out !== 2'b10) begin errors++; $display("FAIL rstp_setup got pend=%b state=%b exp 1/10", pending, state_out); end
      #3 rst_n = 1'b0;
      #1;
      checks++; if ({state_out, select_text, page, update, pending} !== 8'h00) begin errors++; $display("FAIL rstp_async got state=%b sel=%0d page=%0d upd=%b pend=%b exp all 0", state_out, select_text, page, update, pending); end
      cyc(2);
      rst_n = 1'b1;
      cyc(2);
      upd_cnt = 0;
      frame();
      checks++; if (state_out !== 2'b00 || pending !== 1'b0 || upd_cnt !== 0) begin errors++; $display("FAIL rstp_discard got state=%b pend=%b upd=%0d exp 00/0/0", state_out, pending, upd_cnt); end
   endtask

   initial begin
      test_reset();
      test_hold_key();
      test_pages();
      test_last_wins();
      test_coincident();
      test_timeout();
      test_reset_pending(4'hE);
      test_reset_pending(4'h2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
